// File: rtl/mul_vector_serial_pkg.sv
// mul_vec_pkg: shared types and helpers for the word-serial vector multiplier.
//   state_t     : FSM states (IDLE, CALC, DONE)
//   mode_t      : operation mode (FULL multi-word product, LANE word-wise products)
//   words_out() : number of result words for an n-word operand
package mul_vec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      MODE_FULL = 1'b0,
      MODE_LANE = 1'b1
   } mode_t;

   function automatic int words_out(input int n);
      return 2 * n;
   endfunction

endpackage

// File: rtl/mul_vector_serial_if.sv
// mul_vector_serial_if: operand/result handshake bundle for mul_vector_serial.
//   in_valid/in_ready   : operand handshake (a, b, mode accompany in_valid)
//   out_valid/out_ready : result handshake (y accompanies out_valid)
//   busy                : multiplier is stepping through partial products
//   master modport = producer/consumer side, slave modport = multiplier side.
interface mul_vector_serial_if
   import mul_vec_pkg::*;
#(
   parameter int WORD_W = 16,
   parameter int N_IN   = 2
);
   logic                                in_valid;
   logic                                in_ready;
   logic                                mode;
   logic [N_IN*WORD_W-1:0]              a;
   logic [N_IN*WORD_W-1:0]              b;
   logic                                out_valid;
   logic                                out_ready;
   logic [words_out(N_IN)*WORD_W-1:0]   y;
   logic                                busy;

   modport master (
      output in_valid, mode, a, b, out_ready,
      input  in_ready, out_valid, y, busy
   );

   modport slave (
      input  in_valid, mode, a, b, out_ready,
      output in_ready, out_valid, y, busy
   );
endinterface

// File: rtl/mul_vector_serial_mul_word.sv
// mul_word: combinational WORD_W x WORD_W unsigned multiplier.
//   a, b : unsigned words
//   p    : full-width 2*WORD_W product
module mul_word
#(
   parameter int WORD_W = 16
) (
   input  logic [WORD_W-1:0]   a,
   input  logic [WORD_W-1:0]   b,
   output logic [2*WORD_W-1:0] p
);
   assign p = {{WORD_W{1'b0}}, a} * {{WORD_W{1'b0}}, b};
endmodule

// File: rtl/mul_vector_serial.sv
// mul_vector_serial: word-serial multi-word unsigned multiplier.
//   One WORD_W x WORD_W partial product is folded into a wide accumulator per clock.
//   FULL mode builds {a}*{b} in N_IN*N_IN steps; LANE mode builds a[k]*b[k] per word
//   pair in N_IN steps. One operation in flight.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mul_vector_serial_if (operand/result handshakes, busy)
module mul_vector_serial
   import mul_vec_pkg::*;
#(
   parameter int WORD_W = 16,
   parameter int N_IN   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mul_vector_serial_if.slave   bus
);
   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int OW = N_IN * WORD_W;
   localparam int AW = words_out(N_IN) * WORD_W;
   localparam logic [IW-1:0] LAST = IW'(N_IN - 1);

   state_t              state, state_nxt;
   mode_t               mode_r;
   logic [OW-1:0]       a_r, b_r;
   logic [AW-1:0]       acc, acc_nxt, y_r;
   logic [IW-1:0]       i_r, j_r, bsel;
   logic [WORD_W-1:0]   op_a, op_b;
   logic [2*WORD_W-1:0] prod;
   logic                accept, last_step, row_end;

   assign accept    = bus.in_valid && (state == IDLE);
   // In LANE mode every step finishes a "row": j is unused and i walks the lanes.
   assign row_end   = (mode_r == MODE_LANE) || (j_r == LAST);
   assign last_step = (state == CALC) && (i_r == LAST) && row_end;

   // Operand word select: FULL pairs a[i] with b[j], LANE pairs a[k] with b[k].
   always_comb begin
      bsel = (mode_r == MODE_LANE) ? i_r : j_r;
      op_a = a_r[i_r*WORD_W +: WORD_W];
      op_b = b_r[bsel*WORD_W +: WORD_W];
   end

   mul_word #(.WORD_W(WORD_W)) u_mul (
      .a (op_a),
      .b (op_b),
      .p (prod)
   );

   // FULL adds the shifted partial product across the whole width (cannot overflow);
   // LANE overwrites its own two-word slot, so lanes never carry into each other.
   always_comb begin
      acc_nxt = acc;
      if (mode_r == MODE_FULL)
         acc_nxt = acc + (AW'(prod) << (WORD_W * (int'(i_r) + int'(j_r))));
      else
         acc_nxt[int'(i_r)*2*WORD_W +: 2*WORD_W] = prod;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nxt = CALC;
         CALC:    if (last_step)     state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // Control: state, step counters and the result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         i_r   <= '0;
         j_r   <= '0;
         y_r   <= '0;
      end else begin
         state <= state_nxt;
         if (accept || last_step) begin
            i_r <= '0;
            j_r <= '0;
         end else if (state == CALC) begin
            if (row_end) begin
               j_r <= '0;
               i_r <= i_r + 1'b1;
            end else begin
               j_r <= j_r + 1'b1;
            end
         end
         // Result is captured on the edge that enters DONE, so out_valid and y rise together.
         if (last_step)
            y_r <= acc_nxt;
      end
   end

   // Datapath: operands are only sampled on the accepting edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_r    <= bus.a;
         b_r    <= bus.b;
         mode_r <= mode_t'(bus.mode);
         acc    <= '0;
      end else if (state == CALC) begin
         acc <= acc_nxt;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state == CALC);
   assign bus.out_valid = (state == DONE);
   assign bus.y         = y_r;

endmodule

// File: tb/tb_mul_vector_serial.sv
module tb_mul_vector_serial;

   typedef struct {
      logic [63:0] y;
      int          edge_no;
      int          lat;
   } sb_t;

   localparam int NW[2] = '{2, 4};
   localparam int WW[2] = '{16, 8};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic        iv[2], md[2], ordy[2];
   logic [31:0] ad[2], bd[2];
   logic        ir[2], ov[2], bz[2];
   logic [63:0] yv[2];

   int checks = 0;
   int errors = 0;
   sb_t q[2][$];

   mul_vector_serial_if #(.WORD_W(16), .N_IN(2)) ifa ();
   mul_vector_serial_if #(.WORD_W(8),  .N_IN(4)) ifb ();

   mul_vector_serial #(.WORD_W(16), .N_IN(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   mul_vector_serial #(.WORD_W(8),  .N_IN(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   assign ifa.in_valid  = iv[0];
   assign ifa.mode      = md[0];
   assign ifa.a         = ad[0];
   assign ifa.b         = bd[0];
   assign ifa.out_ready = ordy[0];
   assign ifb.in_valid  = iv[1];
   assign ifb.mode      = md[1];
   assign ifb.a         = ad[1];
   assign ifb.b         = bd[1];
   assign ifb.out_ready = ordy[1];
   assign ir[0] = ifa.in_ready;
   assign ov[0] = ifa.out_valid;
   assign bz[0] = ifa.busy;
   assign yv[0] = ifa.y;
   assign ir[1] = ifb.in_ready;
   assign ov[1] = ifb.out_valid;
   assign bz[1] = ifb.busy;
   assign yv[1] = ifb.y;

   // Reference: FULL is one wide integer product; LANE multiplies each word pair into its slot.
   function automatic logic [63:0] model(input int d, input logic m, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] r, mask, aw, bw;
      int w, n;
      w = WW[d];
      n = NW[d];
      if (!m) return {32'd0, a} * {32'd0, b};
      mask = (64'd1 << w) - 64'd1;
      r = '0;
      for (int k = 0; k < n; k++) begin
         aw = ({32'd0, a} >> (k * w)) & mask;
         bw = ({32'd0, b} >> (k * w)) & mask;
         r  = r | ((aw * bw) << (2 * k * w));
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pushes on accept, pops and compares when a result appears.
   initial begin : monitor
      sb_t  cur[2];
      logic ovp[2];
      logic hsp[2];
      int   bcnt[2];
      for (int d = 0; d < 2; d++) begin
         ovp[d] = 1'b0;
         hsp[d] = 1'b0;
         bcnt[d] = 0;
         cur[d] = '{y: '0, edge_no: 0, lat: 0};
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
               q[d].delete();
               ovp[d] = 1'b0;
               hsp[d] = 1'b0;
               bcnt[d] = 0;
            end else begin
               if (hsp[d]) chk($sformatf("in_ready_after_handshake%0d", d), 64'(ir[d]), 64'd1);
               if (iv[d] && ir[d]) begin
                  q[d].push_back('{y: model(d, md[d], ad[d], bd[d]), edge_no: cyc + 1,
                                   lat: md[d] ? NW[d] : NW[d] * NW[d]});
                  bcnt[d] = 0;
               end
               if (bz[d]) bcnt[d]++;
               if (ov[d] && !ovp[d]) begin
                  if (q[d].size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL spurious_result%0d: got y=%h expected no out_valid", d, yv[d]);
                  end else begin
                     cur[d] = q[d].pop_front();
                     chk($sformatf("result%0d", d), yv[d], cur[d].y);
                     chk($sformatf("latency%0d", d), 64'(cyc - cur[d].edge_no), 64'(cur[d].lat));
                     chk($sformatf("busy_cycles%0d", d), 64'(bcnt[d]), 64'(cur[d].lat));
                  end
               end else if (ov[d]) begin
                  chk($sformatf("y_hold%0d", d), yv[d], cur[d].y);
                  chk($sformatf("in_ready_low_done%0d", d), 64'(ir[d]), 64'd0);
               end
               hsp[d] = ov[d] && ordy[d];
               ovp[d] = ov[d];
            end
         end
      end
   end

   // One operation: issue, optionally disturb inputs during CALC, stall the result, take it.
   task automatic do_op(input int d, input logic m, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit hold_iv, input bit scramble,
                        input bit has_exp, input logic [63:0] exp, input bit now);
      int t;
      if (!now) begin
         @(posedge clk); #1;
      end
      t = 0;
      while (!ir[d] && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!ir[d]) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout%0d: got in_ready=0 expected 1 within 100 cycles", d);
         return;
      end
      iv[d] = 1'b1;
      md[d] = m;
      ad[d] = a;
      bd[d] = b;
      ordy[d] = (stall == 0);
      @(posedge clk); #1;
      iv[d] = hold_iv;
      if (scramble) begin
         ad[d] = $urandom;
         bd[d] = $urandom;
         md[d] = ~m;
      end
      t = 0;
      while (!ov[d] && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!ov[d]) begin
         checks++;
         errors++;
         $display("FAIL result_timeout%0d: got out_valid=0 expected 1 within 100 cycles", d);
         iv[d] = 1'b0;
         ordy[d] = 1'b1;
         return;
      end
      if (has_exp) chk($sformatf("known_result%0d", d), yv[d], exp);
      repeat (stall) begin
         @(posedge clk); #1;
      end
      iv[d] = 1'b0;
      ordy[d] = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("out_valid_drop%0d", d), 64'(ov[d]), 64'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish expected completion before 400us");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [63:0] last_y;
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0;
         md[d] = 1'b0;
         ad[d] = '0;
         bd[d] = '0;
         ordy[d] = 1'b1;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_out_valid%0d", d), 64'(ov[d]), 64'd0);
         chk($sformatf("reset_y%0d", d), yv[d], 64'd0);
         chk($sformatf("reset_in_ready%0d", d), 64'(ir[d]), 64'd1);
         chk($sformatf("reset_busy%0d", d), 64'(bz[d]), 64'd0);
      end
      rst_n = 1'b1;

      // FULL all-ones and LANE with no inter-lane carry
      do_op(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1, 64'hFFFF_FFFE_0000_0001, 0);
      do_op(0, 1'b1, 32'h0003_FFFF, 32'h0005_FFFF, 0, 0, 0, 1, 64'h0000_000F_FFFE_0001, 0);
      // back-pressure for 10 cycles with in_valid held high
      do_op(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1, 0, 1, 64'hFFFF_FFFE_0000_0001, 0);

      // reset in the middle of CALC
      last_y = yv[0];
      chk("y_kept_after_handshake", yv[0], last_y);
      @(posedge clk); #1;
      iv[0] = 1'b1;
      md[0] = 1'b0;
      ad[0] = 32'hFFFF_FFFF;
      bd[0] = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", 64'(ov[0]), 64'd0);
      chk("midreset_y", yv[0], 64'd0);
      chk("midreset_busy", 64'(bz[0]), 64'd0);
      chk("midreset_in_ready", 64'(ir[0]), 64'd1);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_op(0, 1'b0, 32'h0000_0002, 32'h0000_0003, 0, 0, 0, 1, 64'd6, 1);

      // operands disturbed during CALC; zero operands
      do_op(0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 1, 1, 64'h0B00_EA4E_242D_2080, 0);
      do_op(0, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 2, 1, 1, 0, 64'd0, 0);
      do_op(0, 1'b0, 32'h0000_0000, $urandom, 0, 0, 1, 1, 64'd0, 0);
      do_op(1, 1'b0, $urandom, 32'h0000_0000, 1, 0, 1, 1, 64'd0, 0);

      // randomized traffic with random result stalls
      for (int n = 0; n < 40; n++) begin
         do_op(1, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 64'd0, 0);
      end
      for (int n = 0; n < 12; n++) begin
         do_op(0, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3),
               0, 1'($urandom_range(0, 1)), 0, 64'd0, 0);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", 64'(q[0].size() + q[1].size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
